// File: rtl/fsa_pkg.sv
// Shared definitions for the frame-sync controller: state encoding and state type.
package fsa_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_SYNC     = 2'd2;
  localparam logic [1:0] ST_ACTIVE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    WAIT_SOF = ST_WAIT_SOF,
    SYNC     = ST_SYNC,
    ACTIVE   = ST_ACTIVE
  } fsa_state_e;

endpackage

// File: rtl/fsa_result_shadow.sv
// Shadow and staging registers for frame geometry and edge results.
// Shadows move only on the one-cycle load strobe, so downstream logic sees
// values that stay constant for a whole frame.
module fsa_result_shadow
  import fsa_pkg::*;
#(
  parameter int C_IMG_WW = 12,
  parameter int C_IMG_HW = 12
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic [C_IMG_WW-1:0] width,
  input  logic [C_IMG_HW-1:0] height,
  input  logic                res_update,
  input  logic                lft_valid,
  input  logic [C_IMG_WW-1:0] lft_edge,
  input  logic                rt_valid,
  input  logic [C_IMG_WW-1:0] rt_edge,
  output logic                sh_lft_valid,
  output logic [C_IMG_WW-1:0] sh_lft_edge,
  output logic                sh_rt_valid,
  output logic [C_IMG_WW-1:0] sh_rt_edge,
  output logic [C_IMG_WW-1:0] sh_width,
  output logic [C_IMG_HW-1:0] sh_height
);

  logic                stg_lft_valid_q, stg_lft_valid_d;
  logic [C_IMG_WW-1:0] stg_lft_edge_q,  stg_lft_edge_d;
  logic                stg_rt_valid_q,  stg_rt_valid_d;
  logic [C_IMG_WW-1:0] stg_rt_edge_q,   stg_rt_edge_d;
  logic                pending_q,       pending_d;
  logic                sh_lft_valid_q,  sh_lft_valid_d;
  logic [C_IMG_WW-1:0] sh_lft_edge_q,   sh_lft_edge_d;
  logic                sh_rt_valid_q,   sh_rt_valid_d;
  logic [C_IMG_WW-1:0] sh_rt_edge_q,    sh_rt_edge_d;
  logic [C_IMG_WW-1:0] sh_width_q,      sh_width_d;
  logic [C_IMG_HW-1:0] sh_height_q,     sh_height_d;

  // Next-state: stage updates between frames, publish them on load.
  always_comb begin
    stg_lft_valid_d = stg_lft_valid_q;
    stg_lft_edge_d  = stg_lft_edge_q;
    stg_rt_valid_d  = stg_rt_valid_q;
    stg_rt_edge_d   = stg_rt_edge_q;
    pending_d       = pending_q;
    sh_lft_valid_d  = sh_lft_valid_q;
    sh_lft_edge_d   = sh_lft_edge_q;
    sh_rt_valid_d   = sh_rt_valid_q;
    sh_rt_edge_d    = sh_rt_edge_q;
    sh_width_d      = sh_width_q;
    sh_height_d     = sh_height_q;

    if (load) begin
      // A zero dimension would make the wrap compare unreachable; treat it as 1.
      sh_width_d  = (width  == '0) ? C_IMG_WW'(1) : width;
      sh_height_d = (height == '0) ? C_IMG_HW'(1) : height;
      pending_d   = 1'b0;
      if (res_update) begin
        // Fresh inputs on the load cycle are newer than anything staged.
        sh_lft_valid_d = lft_valid;
        sh_lft_edge_d  = lft_edge;
        sh_rt_valid_d  = rt_valid;
        sh_rt_edge_d   = rt_edge;
      end else if (pending_q) begin
        sh_lft_valid_d = stg_lft_valid_q;
        sh_lft_edge_d  = stg_lft_edge_q;
        sh_rt_valid_d  = stg_rt_valid_q;
        sh_rt_edge_d   = stg_rt_edge_q;
      end
    end else if (res_update) begin
      stg_lft_valid_d = lft_valid;
      stg_lft_edge_d  = lft_edge;
      stg_rt_valid_d  = rt_valid;
      stg_rt_edge_d   = rt_edge;
      pending_d       = 1'b1;
    end
  end

  // Register bank with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stg_lft_valid_q <= 1'b0;
      stg_lft_edge_q  <= '0;
      stg_rt_valid_q  <= 1'b0;
      stg_rt_edge_q   <= '0;
      pending_q       <= 1'b0;
      sh_lft_valid_q  <= 1'b0;
      sh_lft_edge_q   <= '0;
      sh_rt_valid_q   <= 1'b0;
      sh_rt_edge_q    <= '0;
      sh_width_q      <= '0;
      sh_height_q     <= '0;
    end else begin
      stg_lft_valid_q <= stg_lft_valid_d;
      stg_lft_edge_q  <= stg_lft_edge_d;
      stg_rt_valid_q  <= stg_rt_valid_d;
      stg_rt_edge_q   <= stg_rt_edge_d;
      pending_q       <= pending_d;
      sh_lft_valid_q  <= sh_lft_valid_d;
      sh_lft_edge_q   <= sh_lft_edge_d;
      sh_rt_valid_q   <= sh_rt_valid_d;
      sh_rt_edge_q    <= sh_rt_edge_d;
      sh_width_q      <= sh_width_d;
      sh_height_q     <= sh_height_d;
    end
  end

  assign sh_lft_valid = sh_lft_valid_q;
  assign sh_lft_edge  = sh_lft_edge_q;
  assign sh_rt_valid  = sh_rt_valid_q;
  assign sh_rt_edge   = sh_rt_edge_q;
  assign sh_width     = sh_width_q;
  assign sh_height    = sh_height_q;

endmodule

// File: rtl/fsa_frame_ctl.sv
// Frame controller: locks onto start-of-frame in an AXI-Stream video feed,
// forwards pixels with zero latency while tagging them with (x,y), and
// flags line-length and unexpected start-of-frame errors.
module fsa_frame_ctl
  import fsa_pkg::*;
#(
  parameter int C_IMG_WW = 12,
  parameter int C_IMG_HW = 12,
  parameter int C_DW     = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [C_IMG_WW-1:0] width,
  input  logic [C_IMG_HW-1:0] height,
  input  logic                s_axis_tvalid,
  input  logic [C_DW-1:0]     s_axis_tdata,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                m_axis_tvalid,
  output logic [C_DW-1:0]     m_axis_tdata,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic [C_IMG_WW-1:0] m_axis_source_x,
  output logic [C_IMG_HW-1:0] m_axis_source_y,
  output logic                fsync,
  output logic                busy,
  input  logic                res_update,
  input  logic                lft_valid,
  input  logic [C_IMG_WW-1:0] lft_edge,
  input  logic                rt_valid,
  input  logic [C_IMG_WW-1:0] rt_edge,
  output logic                sh_lft_valid,
  output logic [C_IMG_WW-1:0] sh_lft_edge,
  output logic                sh_rt_valid,
  output logic [C_IMG_WW-1:0] sh_rt_edge,
  output logic [C_IMG_WW-1:0] sh_width,
  output logic [C_IMG_HW-1:0] sh_height,
  output logic                err_line,
  output logic                err_sof,
  input  logic                err_clr
);

  fsa_state_e          state_q, state_d;
  logic [C_IMG_WW-1:0] x_q, x_d;
  logic [C_IMG_HW-1:0] y_q, y_d;
  logic                err_line_q, err_line_d;
  logic                err_sof_q, err_sof_d;
  logic                line_set;
  logic                sof_set;
  logic                last_col;
  logic                last_row;
  logic                in_sync;

  assign in_sync  = (state_q == SYNC);
  assign last_col = (x_q == sh_width  - C_IMG_WW'(1));
  assign last_row = (y_q == sh_height - C_IMG_HW'(1));

  fsa_result_shadow #(
    .C_IMG_WW (C_IMG_WW),
    .C_IMG_HW (C_IMG_HW)
  ) u_shadow (
    .clk          (clk),
    .resetn       (resetn),
    .load         (in_sync),
    .width        (width),
    .height       (height),
    .res_update   (res_update),
    .lft_valid    (lft_valid),
    .lft_edge     (lft_edge),
    .rt_valid     (rt_valid),
    .rt_edge      (rt_edge),
    .sh_lft_valid (sh_lft_valid),
    .sh_lft_edge  (sh_lft_edge),
    .sh_rt_valid  (sh_rt_valid),
    .sh_rt_edge   (sh_rt_edge),
    .sh_width     (sh_width),
    .sh_height    (sh_height)
  );

  // Next-state, counters and stream outputs.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    fsync         = 1'b0;
    busy          = 1'b0;
    line_set      = 1'b0;
    sof_set       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SOF;
      end

      WAIT_SOF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (s_axis_tvalid && s_axis_tuser) begin
          // Leave the SOF beat in the input register; it is taken in ACTIVE.
          state_d = SYNC;
        end else begin
          s_axis_tready = 1'b1;
        end
      end

      SYNC: begin
        fsync   = 1'b1;
        busy    = 1'b1;
        x_d     = '0;
        y_d     = '0;
        state_d = ACTIVE;
      end

      ACTIVE: begin
        busy = 1'b1;
        if (s_axis_tvalid && s_axis_tuser && ((x_q != '0) || (y_q != '0))) begin
          // Early SOF: abandon the current frame and resync on this beat.
          sof_set = 1'b1;
          state_d = SYNC;
        end else begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tuser  = s_axis_tuser;
          m_axis_tlast  = s_axis_tlast;
          if (s_axis_tvalid && m_axis_tready) begin
            if (s_axis_tlast != last_col) line_set = 1'b1;
            if (last_col) begin
              x_d = '0;
              if (last_row) begin
                y_d     = '0;
                state_d = enable ? WAIT_SOF : IDLE;
              end else begin
                y_d = y_q + C_IMG_HW'(1);
              end
            end else begin
              x_d = x_q + C_IMG_WW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Sticky flags: a new error in the clear cycle keeps the flag set.
    err_line_d = (err_line_q & ~err_clr) | line_set;
    err_sof_d  = (err_sof_q  & ~err_clr) | sof_set;
  end

  // State, counters and error flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      err_line_q <= 1'b0;
      err_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_line_q <= err_line_d;
      err_sof_q  <= err_sof_d;
    end
  end

  assign m_axis_source_x = x_q;
  assign m_axis_source_y = y_q;
  assign err_line        = err_line_q;
  assign err_sof         = err_sof_q;

endmodule

// File: tb/tb_fsa_frame_ctl.sv
// Scoreboard bench for fsa_frame_ctl: expected beats are queued as stimulus
// is driven and compared when they appear on the master side.
module tb_fsa_frame_ctl;

  localparam int WW = 12;
  localparam int HW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic [WW-1:0] width = '0;
  logic [HW-1:0] height = '0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tuser = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_tready = 1'b1;
  logic [WW-1:0] src_x;
  logic [HW-1:0] src_y;
  logic          fsync;
  logic          busy;
  logic          res_update = 1'b0;
  logic          lft_valid = 1'b0;
  logic [WW-1:0] lft_edge = '0;
  logic          rt_valid = 1'b0;
  logic [WW-1:0] rt_edge = '0;
  logic          sh_lft_valid;
  logic [WW-1:0] sh_lft_edge;
  logic          sh_rt_valid;
  logic [WW-1:0] sh_rt_edge;
  logic [WW-1:0] sh_width;
  logic [HW-1:0] sh_height;
  logic          err_line;
  logic          err_sof;
  logic          err_clr = 1'b0;

  always #5 clk = ~clk;

  fsa_frame_ctl #(.C_IMG_WW(WW), .C_IMG_HW(HW), .C_DW(DW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .width           (width),
    .height          (height),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tdata    (s_tdata),
    .s_axis_tuser    (s_tuser),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_tready),
    .m_axis_source_x (src_x),
    .m_axis_source_y (src_y),
    .fsync           (fsync),
    .busy            (busy),
    .res_update      (res_update),
    .lft_valid       (lft_valid),
    .lft_edge        (lft_edge),
    .rt_valid        (rt_valid),
    .rt_edge         (rt_edge),
    .sh_lft_valid    (sh_lft_valid),
    .sh_lft_edge     (sh_lft_edge),
    .sh_rt_valid     (sh_rt_valid),
    .sh_rt_edge      (sh_rt_edge),
    .sh_width        (sh_width),
    .sh_height       (sh_height),
    .err_line        (err_line),
    .err_sof         (err_sof),
    .err_clr         (err_clr)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    int            x;
    int            y;
  } beat_t;

  beat_t sbq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    fsync_cnt = 0;
  int    fsync_cyc = 0;
  int    first_hs_cyc = 0;
  bit    tog_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Backpressure generator for the master side.
  initial forever begin
    @(posedge clk);
    #1;
    if (tog_en) m_tready = ~m_tready;
  end

  // Output monitor: every master-side handshake is checked against the queue.
  initial forever begin
    @(negedge clk);
    if (fsync) begin
      fsync_cnt++;
      fsync_cyc = cyc;
    end
    if (m_axis_tvalid && m_tready) begin
      hs_cnt++;
      if (sbq.size() == 0) begin
        chk("sb_empty_on_beat", sbq.size(), 1);
      end else begin
        beat_t e;
        e = sbq.pop_front();
        chk("px_data", m_axis_tdata, e.d);
        chk("px_user", m_axis_tuser, e.u);
        chk("px_last", m_axis_tlast, e.l);
        chk("px_x", src_x, e.x);
        chk("px_y", src_y, e.y);
        if (e.u) first_hs_cyc = cyc;
        $display("beat data=%0h x=%0d y=%0d user=%0d last=%0d", m_axis_tdata, src_x, src_y, m_axis_tuser, m_axis_tlast);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one slave beat and hold it until the slave side accepts it.
  task automatic send(input logic [DW-1:0] d, input logic u, input logic l,
                      input bit pass, input int ex, input int ey);
    if (pass) begin
      beat_t e;
      e.d = d; e.u = u; e.l = l; e.x = ex; e.y = ey;
      sbq.push_back(e);
    end
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        if (!pass) chk("drop_no_out", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        return;
      end
    end
    chk("hs_timeout", s_axis_tready, 1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        send(DW'($urandom), (xx == 0 && yy == 0), (xx == w - 1), 1'b1, xx, yy);
  endtask

  initial begin
    int f0;
    int h0;
    bit seen;

    // Reset state, with a request already pending.
    enable = 1'b1; width = 12'd4; height = 12'd2;
    repeat (2) @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_fsync", fsync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_line", err_line, 0);
    chk("rst_err_sof", err_sof, 0);
    chk("rst_sh_width", sh_width, 0);
    chk("rst_sh_height", sh_height, 0);
    chk("rst_src_x", src_x, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Basic 4x2 frame.
    f0 = fsync_cnt;
    send_frame(4, 2);
    tick(2);
    chk("f1_fsync_cnt", fsync_cnt - f0, 1);
    chk("f1_err_line", err_line, 0);
    chk("f1_err_sof", err_sof, 0);
    chk("f1_sh_width", sh_width, 4);
    chk("f1_sh_height", sh_height, 2);
    chk("f1_busy_after", busy, 0);
    chk("f1_sb_drained", sbq.size(), 0);
    // Back in WAIT_SOF: a non-SOF beat is accepted and dropped.
    send(8'h11, 1'b0, 1'b0, 1'b0, 0, 0);

    // Three dropped beats, then a frame; fsync leads the first pixel by one cycle.
    for (int i = 0; i < 3; i++) send(DW'(8'h20 + i), 1'b0, (i == 2), 1'b0, 0, 0);
    send_frame(4, 2);
    tick(1);
    chk("fsync_lead", first_hs_cyc - fsync_cyc, 1);

    // Early SOF at (2,1): flagged, withheld, restarts the frame at (0,0).
    f0 = fsync_cnt;
    for (int k = 0; k < 6; k++) send(DW'($urandom), (k == 0), (k % 4 == 3), 1'b1, k % 4, k / 4);
    send(8'h5a, 1'b1, 1'b0, 1'b1, 0, 0);
    chk("sof_err_set", err_sof, 1);
    for (int k = 1; k < 8; k++) send(DW'($urandom), 1'b0, (k % 4 == 3), 1'b1, k % 4, k / 4);
    tick(1);
    chk("sof_fsync_cnt", fsync_cnt - f0, 2);
    chk("sof_no_line_err", err_line, 0);

    // Clear, then a misplaced tlast at x=1; counters keep counting.
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("clr_err_sof", err_sof, 0);
    for (int k = 0; k < 8; k++) send(DW'($urandom), (k == 0), (k % 4 == 3) || (k == 1), 1'b1, k % 4, k / 4);
    tick(1);
    chk("line_err_set", err_line, 1);
    chk("line_err_sof_clear", err_sof, 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("line_err_cleared", err_line, 0);

    // Mid-frame result update is held until the next SYNC.
    for (int k = 0; k < 8; k++) begin
      send(DW'($urandom), (k == 0), (k % 4 == 3), 1'b1, k % 4, k / 4);
      if (k == 2) begin
        res_update = 1'b1; lft_valid = 1'b1; lft_edge = 12'd100;
        tick(1);
        res_update = 1'b0; lft_edge = 12'd7;
        chk("upd_held_edge", sh_lft_edge, 0);
      end
    end
    tick(1);
    chk("upd_held_frame_end", sh_lft_edge, 0);
    send_frame(4, 2);
    chk("upd_applied_edge", sh_lft_edge, 100);
    chk("upd_applied_valid", sh_lft_valid, 1);

    // Update coinciding with SYNC goes straight to the shadow.
    fork
      send_frame(4, 2);
      begin
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
          @(negedge clk);
          if (fsync) begin
            seen = 1'b1;
            res_update = 1'b1; lft_edge = 12'd55;
          end
        end
        chk("sync_seen", seen, 1);
        @(posedge clk); #1;
        res_update = 1'b0;
      end
    join
    chk("upd_sync_direct", sh_lft_edge, 55);
    send_frame(4, 2);
    chk("upd_pending_cleared", sh_lft_edge, 55);

    // Zero geometry latches as 1x1: a single beat is a whole frame.
    width = '0; height = '0;
    send(8'h77, 1'b1, 1'b1, 1'b1, 0, 0);
    tick(2);
    chk("zero_sh_width", sh_width, 1);
    chk("zero_sh_height", sh_height, 1);
    chk("zero_err_line", err_line, 0);
    chk("zero_busy", busy, 0);
    width = 12'd4; height = 12'd2;

    // Toggling backpressure: counters advance on handshakes only.
    h0 = hs_cnt;
    tog_en = 1'b1;
    send_frame(4, 2);
    tog_en = 1'b0; m_tready = 1'b1;
    tick(1);
    chk("bp_handshakes", hs_cnt - h0, 8);
    chk("bp_err_line", err_line, 0);
    chk("bp_sb_drained", sbq.size(), 0);

    // Reset mid-frame discards the frame.
    for (int k = 0; k < 3; k++) send(DW'($urandom), (k == 0), 1'b0, 1'b1, k, 0);
    s_tvalid = 1'b1; s_tdata = 8'haa;
    #3 resetn = 1'b0;
    #1;
    chk("mrst_m_tvalid", m_axis_tvalid, 0);
    chk("mrst_m_tdata", m_axis_tdata, 0);
    chk("mrst_s_tready", s_axis_tready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_src_x", src_x, 0);
    chk("mrst_sh_width", sh_width, 0);
    chk("mrst_sh_lft_edge", sh_lft_edge, 0);
    s_tvalid = 1'b0;
    sbq.delete();
    tick(1);
    resetn = 1'b1;
    send(8'h33, 1'b0, 1'b1, 1'b0, 0, 0);
    send_frame(4, 2);
    tick(2);
    chk("post_rst_sh_width", sh_width, 4);
    chk("post_rst_busy", busy, 0);
    chk("final_sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
